branch_predictor: RTL

- Bimodal direction predictor feeding the fetch stage: produces the target_taken prediction that the execute stage checks.
- Consumes execute-stage resolution (branch flag, actual outcome, predicted outcome) to train a table of 2-bit saturating counters.
- Keeps wrapping branch and mispredict performance counters, read via CSR.
- Prediction is registered, aligned with the one-cycle synchronous instruction-memory read.

---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 108 ++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the bimodal branch predictor: 2-bit counter state encodings
// and the counter reset value.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_state_e;

  localparam logic [1:0] CNT_RESET = CNT_WNT;

  // Direction implied by a counter value.
  function automatic logic cnt_predict(input logic [1:0] cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state logic used on the predictor update path.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  // Step one state toward the resolved direction, saturating at both ends.
  always_comb begin
    next = cur;
    case (cur)
      CNT_SNT: next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  next = taken ? CNT_ST  : CNT_WT;
      default: next = CNT_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor with registered prediction and branch/mispredict counters.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the table index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         fetch_pc,
  input  logic                fetch_stall,
  output logic                pred_taken,
  input  logic                ex_br_inst,
  input  logic [31:0]         ex_pc,
  input  logic                ex_br_taken,
  input  logic                ex_target_taken,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mispred_count
`ifdef BP_GSHARE_EN
  ,
  output logic [IDX_BITS-1:0] pred_ghr,
  input  logic [IDX_BITS-1:0] ex_ghr
`endif
);

  localparam int TBL_N = 2 ** IDX_BITS;

  logic [1:0]          table_r [TBL_N];
  logic [IDX_BITS-1:0] pred_idx_s;
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [1:0]          upd_cur_s;
  logic [1:0]          upd_next_s;
  logic                mispred_s;
  logic                unused_pc_bits_s;

  // Only the word-index bits of each PC reach the table.
  assign unused_pc_bits_s = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                              ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_r;

  assign pred_idx_s = fetch_pc[IDX_BITS+1:2] ^ ghr_r;
  assign upd_idx_s  = ex_pc[IDX_BITS+1:2] ^ ex_ghr;

  // History shifts in each resolved outcome, so it only ever holds committed branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r    <= {IDX_BITS{1'b0}};
      pred_ghr <= {IDX_BITS{1'b0}};
    end else begin
      if (ex_br_inst) begin
        ghr_r <= {ghr_r[IDX_BITS-2:0], ex_br_taken};
      end
      if (!fetch_stall) begin
        pred_ghr <= ghr_r;
      end
    end
  end
`else
  assign pred_idx_s = fetch_pc[IDX_BITS+1:2];
  assign upd_idx_s  = ex_pc[IDX_BITS+1:2];
`endif

  assign upd_cur_s = table_r[upd_idx_s];
  assign mispred_s = ex_target_taken ^ ex_br_taken;

  sat_counter2 u_sat_counter2 (
    .cur   (upd_cur_s),
    .taken (ex_br_taken),
    .next  (upd_next_s)
  );

  // Counter table: every entry resets to weak-NT; one entry trains per resolved branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) begin
        table_r[i] <= CNT_RESET;
      end
    end else if (ex_br_inst) begin
      table_r[upd_idx_s] <= upd_next_s;
    end
  end

  // Prediction register: reads the pre-update table, aligned with the imem read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken <= 1'b0;
    end else if (!fetch_stall) begin
      pred_taken <= cnt_predict(table_r[pred_idx_s]);
    end
  end

  // Performance counters wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= {CNT_W{1'b0}};
      mispred_count <= {CNT_W{1'b0}};
    end else if (ex_br_inst) begin
      br_count <= br_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (mispred_s) begin
        mispred_count <= mispred_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
